bsg_serial_tx: RTL and testbench

- Transmit engine directly downstream of the BSG AMBA register block.
- Consumes BSG_CONTROL[2:0] (TXENABLE, INTMSK, INTFLAG) and the two data registers. Serialises data1 then data2, MSB first, as a 16-bit frame on a single line.
- Returns BSG_CONTROL[7:3] status. Bit 3 (STATUS/busy) gates register writes in the AMBA block.

---
 rtl/bsg_serial_tx.sv | 99 +++++++++
 tb/tb_bsg_serial_tx.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/bsg_serial_tx.sv
// Serial transmit engine behind the BSG AMBA register block: sends {data1,data2}
// MSB first, each bit held CLK_DIV cycles, followed by a CLK_DIV-cycle stop period.
module bsg_serial_tx #(
  parameter int CLK_DIV = 4,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_enable,
  input  logic       int_mask,
  input  logic       int_flag,
  input  logic [7:0] data1,
  input  logic [7:0] data2,
  output logic [4:0] status,
  output logic       serial_out,
  output logic       frame,
  output logic       done_pulse,
  output logic       irq
);

  typedef enum logic [1:0] {IDLE, SHIFT, STOP} state_t;

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);

  state_t           state, state_nxt;
  logic [15:0]      sreg;
  logic [3:0]       bit_cnt;
  logic [CNT_W-1:0] div_cnt;
  logic             done;
  logic             busy;
  logic             div_wrap;

  assign div_wrap = (div_cnt == DIV_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tx_enable) state_nxt = SHIFT;
      SHIFT:   if (div_wrap && (bit_cnt == 4'd0)) state_nxt = STOP;
      STOP:    if (div_wrap) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // done_pulse is registered off the last STOP cycle so it lands on the first IDLE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg       <= '0;
      bit_cnt    <= '0;
      div_cnt    <= '0;
      done       <= 1'b0;
      done_pulse <= 1'b0;
      irq        <= 1'b0;
    end else begin
      done_pulse <= (state == STOP) && div_wrap;
      irq        <= int_mask & (int_flag | done_pulse);
      case (state)
        IDLE: begin
          if (tx_enable) begin
            sreg    <= {data1, data2};
            bit_cnt <= 4'd15;
            div_cnt <= '0;
            done    <= 1'b0;
          end
        end
        SHIFT: begin
          if (div_wrap) begin
            div_cnt <= '0;
            sreg    <= {sreg[14:0], 1'b0};
            if (bit_cnt != 4'd0) bit_cnt <= bit_cnt - 4'd1;
          end else begin
            div_cnt <= div_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (div_wrap) begin
            div_cnt <= '0;
            done    <= 1'b1;
          end else begin
            div_cnt <= div_cnt + CNT_W'(1);
          end
        end
        default: div_cnt <= '0;
      endcase
    end
  end

  // Byte index is gated by busy so the idle/reset status reads all zeros.
  assign busy       = (state != IDLE);
  assign frame      = (state == SHIFT);
  assign serial_out = frame & sreg[15];
  assign status     = {2'b00, busy & ~bit_cnt[3], done, busy};

endmodule

// File: tb/tb_bsg_serial_tx.sv
// Directed bench for bsg_serial_tx: one instance at CLK_DIV=4, one at CLK_DIV=1.
module tb_bsg_serial_tx;

  logic       clk;
  logic       rst;
  logic       tx_enable, int_mask, int_flag;
  logic [7:0] data1, data2;
  logic [4:0] status;
  logic       serial_out, frame, done_pulse, irq;

  logic       tx1;
  logic [7:0] d1a, d1b;
  logic [4:0] status1;
  logic       serial1, frame1, done_pulse1, irq1;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  bsg_serial_tx #(.CLK_DIV(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .tx_enable(tx_enable), .int_mask(int_mask), .int_flag(int_flag),
    .data1(data1), .data2(data2), .status(status), .serial_out(serial_out),
    .frame(frame), .done_pulse(done_pulse), .irq(irq)
  );

  bsg_serial_tx #(.CLK_DIV(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .tx_enable(tx1), .int_mask(1'b0), .int_flag(1'b0),
    .data1(d1a), .data2(d1b), .status(status1), .serial_out(serial1),
    .frame(frame1), .done_pulse(done_pulse1), .irq(irq1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Inputs change on the falling edge so the next rising edge is the start edge.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
    data1     = a;
    data2     = b;
    tx_enable = 1'b1;
  endtask

  // Walks one CLK_DIV=4 frame cycle by cycle, ending on the first IDLE cycle.
  task automatic runFrame(input logic [15:0] word, input bit holdEnable, input int changeAt);
    for (int i = 0; i < 68; i++) begin
      @(negedge clk);
      checkOutput("serial_out", 16'(serial_out), (i < 64) ? 16'(word[15 - i/4]) : 16'd0);
      checkOutput("frame", 16'(frame), (i < 64) ? 16'd1 : 16'd0);
      checkOutput("busy", 16'(status[0]), 16'd1);
      checkOutput("done_cleared", 16'(status[1]), 16'd0);
      checkOutput("no_early_done_pulse", 16'(done_pulse), 16'd0);
      if (i < 64) checkOutput("byte_idx", 16'(status[2]), (i >= 32) ? 16'd1 : 16'd0);
      if (i == 0 && !holdEnable) tx_enable = 1'b0;
      if (i == changeAt) begin
        data1 = ~data1;
        data2 = ~data2;
      end
    end
    @(negedge clk);
    checkOutput("idle_busy", 16'(status[0]), 16'd0);
    checkOutput("idle_done_pulse", 16'(done_pulse), 16'd1);
    checkOutput("idle_done", 16'(status[1]), 16'd1);
    checkOutput("idle_frame", 16'(frame), 16'd0);
    checkOutput("idle_serial", 16'(serial_out), 16'd0);
    checkOutput("status_hi", 16'(status[4:3]), 16'd0);
  endtask

  initial begin
    int busyCycles;
    int pulseCycles;
    logic [15:0] word1;

    rst = 1'b1; tx_enable = 1'b0; int_mask = 1'b0; int_flag = 1'b0;
    data1 = 8'h00; data2 = 8'h00; tx1 = 1'b0; d1a = 8'h00; d1b = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("reset_status", 16'(status), 16'd0);
    checkOutput("reset_serial", 16'(serial_out), 16'd0);
    checkOutput("reset_frame", 16'(frame), 16'd0);
    checkOutput("reset_done_pulse", 16'(done_pulse), 16'd0);
    checkOutput("reset_irq", 16'(irq), 16'd0);
    checkOutput("reset_status1", 16'(status1), 16'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] basic frame A5/3C");
    applyStimulus(8'hA5, 8'h3C);
    runFrame(16'hA53C, 1'b0, -1);
    checkOutput("masked_irq_pulse", 16'(irq), 16'd0);
    @(negedge clk);
    checkOutput("masked_irq_after", 16'(irq), 16'd0);
    checkOutput("pulse_one_cycle", 16'(done_pulse), 16'd0);
    checkOutput("done_sticky", 16'(status[1]), 16'd1);

    $display("[TB] data change mid-frame");
    applyStimulus(8'hFF, 8'h00);
    runFrame(16'hFF00, 1'b0, 10);
    @(negedge clk);

    $display("[TB] continuous mode 81/18");
    applyStimulus(8'h81, 8'h18);
    runFrame(16'h8118, 1'b1, -1);
    runFrame(16'h8118, 1'b0, -1);
    @(negedge clk);

    $display("[TB] interrupt enabled");
    int_mask = 1'b1;
    int_flag = 1'b0;
    applyStimulus(8'h3C, 8'hA5);
    runFrame(16'h3CA5, 1'b0, -1);
    checkOutput("irq_on_pulse", 16'(irq), 16'd0);
    int_flag = 1'b1;
    @(negedge clk);
    checkOutput("irq_after_pulse", 16'(irq), 16'd1);
    @(negedge clk);
    checkOutput("irq_held_by_flag", 16'(irq), 16'd1);
    int_flag = 1'b0;
    @(negedge clk);
    checkOutput("irq_flag_drop", 16'(irq), 16'd0);
    int_mask = 1'b0;
    int_flag = 1'b1;
    @(negedge clk);
    checkOutput("irq_masked_flag", 16'(irq), 16'd0);

    $display("[TB] reset mid-frame");
    int_mask = 1'b1;
    applyStimulus(8'hFF, 8'h0F);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) tx_enable = 1'b0;
      if (i == 19) rst = 1'b1;
    end
    @(negedge clk);
    checkOutput("rst_serial", 16'(serial_out), 16'd0);
    checkOutput("rst_frame", 16'(frame), 16'd0);
    checkOutput("rst_status", 16'(status), 16'd0);
    checkOutput("rst_irq", 16'(irq), 16'd0);
    rst = 1'b0;
    int_mask = 1'b0;
    int_flag = 1'b0;
    busyCycles = 0;
    pulseCycles = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (status[0]) busyCycles++;
      if (done_pulse) pulseCycles++;
    end
    checkOutput("rst_no_restart", 16'(busyCycles), 16'd0);
    checkOutput("rst_no_done_pulse", 16'(pulseCycles), 16'd0);

    $display("[TB] CLK_DIV=1 frame C3/5A");
    word1 = 16'hC35A;
    d1a = 8'hC3;
    d1b = 8'h5A;
    tx1 = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i == 0) tx1 = 1'b0;
      checkOutput("div1_serial", 16'(serial1), (i < 16) ? 16'(word1[15 - i]) : 16'd0);
      checkOutput("div1_frame", 16'(frame1), (i < 16) ? 16'd1 : 16'd0);
      checkOutput("div1_busy", 16'(status1[0]), 16'd1);
    end
    @(negedge clk);
    checkOutput("div1_idle_status", 16'(status1), 16'b00010);
    checkOutput("div1_done_pulse", 16'(done_pulse1), 16'd1);
    checkOutput("div1_irq", 16'(irq1), 16'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
